// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pipe_pkg
//  Description : Shared pipeline constants and stage-entry type for the
//                forwarding / hazard logic of the in-order RV pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

    localparam int RV_REG_AW  = 5;

    // Forward-select encoding: 0 selects the register file, k selects stage k
    localparam int FWD_SEL_RF = 0;
    localparam int STG_EXE    = 1;
    localparam int STG_MEM    = 2;
    localparam int STG_WB     = 3;

    typedef struct packed {
        logic                 v;
        logic [RV_REG_AW-1:0] rd;
        logic                 wr;
        logic                 ld;
    } stage_ent_t;

endpackage
`default_nettype wire

// File: rtl/fwd_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_src_match
//  Description : Priority scan of the tracked stages for one ID source
//                operand; returns its forward select and load-use stall bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_match
    import rv_pipe_pkg::*;
#(
    parameter int NUM_FWD    = 2,
    parameter int REG_AW     = RV_REG_AW,
    parameter int LOAD_STAGE = STG_MEM,
    parameter int SELW       = 2
) (
    input  logic                      i_id_valid,
    input  logic [REG_AW-1:0]         i_src_addr,
    input  logic                      i_src_used,
    input  logic [NUM_FWD-1:0]        i_stg_v,
    input  logic [NUM_FWD*REG_AW-1:0] i_stg_rd,
    input  logic [NUM_FWD-1:0]        i_stg_wr,
    input  logic [NUM_FWD-1:0]        i_stg_ld,
    output logic [SELW-1:0]           o_sel,
    output logic                      o_ld_stall
);

    logic w_found;

    // Youngest stage wins; a too-young load blocks older (stale) producers
    always_comb begin
        o_sel      = SELW'(FWD_SEL_RF);
        o_ld_stall = 1'b0;
        w_found    = 1'b0;
        for (int k = STG_EXE; k <= NUM_FWD; k++) begin
            if (!w_found && i_id_valid && i_src_used &&
                i_stg_v[k-1] && i_stg_wr[k-1] &&
                (i_src_addr != '0) &&
                (i_src_addr == i_stg_rd[(k-1)*REG_AW +: REG_AW])) begin
                w_found = 1'b1;
                if (i_stg_ld[k-1] && (k < LOAD_STAGE)) begin
                    o_ld_stall = 1'b1;
                end else begin
                    o_sel = SELW'(k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Parametrised forwarding select and load-use stall unit in ID.
//                Define FWD_HAZARD_PERF_EN to build the stall/forward counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter  int NUM_SRC    = 2,
    parameter  int NUM_FWD    = 2,
    parameter  int REG_AW     = RV_REG_AW,
    parameter  int LOAD_STAGE = STG_MEM,
    localparam int SELW       = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rd_addr,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               fwd_cnt
);

    // Bit k-1 / slice k-1 holds stage k (stage 1 = EXE)
    logic [NUM_FWD-1:0]        r_v;
    logic [NUM_FWD-1:0]        r_wr;
    logic [NUM_FWD-1:0]        r_ld;
    logic [NUM_FWD*REG_AW-1:0] r_rd;

    logic [NUM_SRC-1:0]        w_src_stall;
    logic                      w_stall;
    logic                      w_bubble;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .NUM_FWD    (NUM_FWD),
            .REG_AW     (REG_AW),
            .LOAD_STAGE (LOAD_STAGE),
            .SELW       (SELW)
        ) u_match (
            .i_id_valid (id_valid),
            .i_src_addr (id_src_addr[i*REG_AW +: REG_AW]),
            .i_src_used (id_src_used[i]),
            .i_stg_v    (r_v),
            .i_stg_rd   (r_rd),
            .i_stg_wr   (r_wr),
            .i_stg_ld   (r_ld),
            .o_sel      (fwd_sel[i*SELW +: SELW]),
            .o_ld_stall (w_src_stall[i])
        );
    end

    assign w_stall  = (|w_src_stall) & ~flush;
    assign w_bubble = w_stall | flush;
    assign stall    = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_wr <= '0;
            r_ld <= '0;
            r_rd <= '0;
        end else if (!hold) begin
            for (int k = NUM_FWD - 1; k >= 1; k--) begin
                r_v[k]                   <= r_v[k-1];
                r_wr[k]                  <= r_wr[k-1];
                r_ld[k]                  <= r_ld[k-1];
                r_rd[k*REG_AW +: REG_AW] <= r_rd[(k-1)*REG_AW +: REG_AW];
            end
            r_v[0]            <= id_valid     & ~w_bubble;
            r_wr[0]           <= id_reg_write & ~w_bubble;
            r_ld[0]           <= id_is_load   & ~w_bubble;
            r_rd[REG_AW-1:0]  <= id_rd_addr;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [15:0]                    r_stall_cnt;
    logic [15:0]                    r_fwd_cnt;
    logic [$clog2(NUM_SRC+1)-1:0]   w_fwd_inc;
    logic [16:0]                    w_fwd_sum;

    // Forwards seen while stalled are re-counted when ID actually advances
    always_comb begin
        w_fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_sel[i*SELW +: SELW] != '0) begin
                w_fwd_inc = w_fwd_inc + 1'b1;
            end
        end
        if (w_stall) begin
            w_fwd_inc = '0;
        end
    end

    assign w_fwd_sum = {1'b0, r_fwd_cnt} + 17'(w_fwd_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!hold) begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            r_fwd_cnt <= w_fwd_sum[16] ? 16'hFFFF : w_fwd_sum[15:0];
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Self-checking bench; two configurations against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           hold, flush, id_valid, reg_write, is_load;
    logic [AW-1:0]  src [0:2];
    logic [2:0]     used;
    logic [AW-1:0]  rd;

    logic [3:0]     sel_a;
    logic [5:0]     sel_b;
    logic           stall_a, stall_b;
    logic [15:0]    scnt_a, fcnt_a, scnt_b, fcnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .REG_AW(AW), .LOAD_STAGE(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_src_addr({src[1], src[0]}), .id_src_used(used[1:0]),
        .id_rd_addr(rd), .id_reg_write(reg_write), .id_is_load(is_load),
        .fwd_sel(sel_a), .stall(stall_a), .stall_cnt(scnt_a), .fwd_cnt(fcnt_a)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .NUM_FWD(3), .REG_AW(AW), .LOAD_STAGE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_src_addr({src[2], src[1], src[0]}), .id_src_used(used),
        .id_rd_addr(rd), .id_reg_write(reg_write), .id_is_load(is_load),
        .fwd_sel(sel_b), .stall(stall_b), .stall_cnt(scnt_b), .fwd_cnt(fcnt_b)
    );

    // Reference model: per configuration an array of in-flight instructions
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    ent_t pipe   [2][1:6];
    int   m_scnt [2];
    int   m_fcnt [2];
    int   e_sel  [2][3];
    bit   e_stall[2];
    int   e_inc  [2];

    function automatic int cfg_ns(int m); return (m == 0) ? 2 : 3; endfunction
    function automatic int cfg_nf(int m); return (m == 0) ? 2 : 3; endfunction
    function automatic int cfg_ls(int m); return (m == 0) ? 2 : 3; endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= 6; k++) pipe[m][k] = '{0, 0, 0, 0};
            m_scnt[m] = 0;
            m_fcnt[m] = 0;
        end
    endtask

    task automatic model_eval(input int m);
        bit any_stall = 0;
        e_inc[m] = 0;
        for (int i = 0; i < cfg_ns(m); i++) begin
            e_sel[m][i] = 0;
            if (!id_valid || !used[i] || src[i] == 0) continue;
            for (int k = 1; k <= cfg_nf(m); k++) begin
                if (pipe[m][k].v && pipe[m][k].wr && pipe[m][k].rd == int'(src[i])) begin
                    if (pipe[m][k].ld && k < cfg_ls(m)) any_stall = 1;
                    else                                e_sel[m][i] = k;
                    break;
                end
            end
        end
        e_stall[m] = any_stall && !flush;
        if (!e_stall[m])
            for (int i = 0; i < cfg_ns(m); i++) if (e_sel[m][i] != 0) e_inc[m]++;
    endtask

    task automatic model_step(input int m);
        if (hold) return;
        for (int k = cfg_nf(m); k >= 2; k--) pipe[m][k] = pipe[m][k-1];
        if (e_stall[m] || flush) pipe[m][1] = '{0, int'(rd), 0, 0};
        else                     pipe[m][1] = '{id_valid, int'(rd), reg_write, is_load};
        if (e_stall[m]) m_scnt[m] = (m_scnt[m] + 1 > 65535) ? 65535 : m_scnt[m] + 1;
        m_fcnt[m] = (m_fcnt[m] + e_inc[m] > 65535) ? 65535 : m_fcnt[m] + e_inc[m];
    endtask

    task automatic model_compare(input int m);
        logic [31:0] act_sel, exp_s, exp_f;
        for (int i = 0; i < cfg_ns(m); i++) begin
            act_sel = (m == 0) ? 32'(sel_a[i*2 +: 2]) : 32'(sel_b[i*2 +: 2]);
            check_val($sformatf("cfg%0d_sel%0d", m, i), act_sel, e_sel[m][i]);
        end
        check_val($sformatf("cfg%0d_stall", m), (m == 0) ? stall_a : stall_b, 32'(e_stall[m]));
`ifdef FWD_HAZARD_PERF_EN
        exp_s = m_scnt[m];
        exp_f = m_fcnt[m];
`else
        exp_s = 0;
        exp_f = 0;
`endif
        check_val($sformatf("cfg%0d_stall_cnt", m), (m == 0) ? scnt_a : scnt_b, exp_s);
        check_val($sformatf("cfg%0d_fwd_cnt", m),   (m == 0) ? fcnt_a : fcnt_b, exp_f);
    endtask

    task automatic drive(input bit v, input int s0, input int s1, input int s2, input bit [2:0] u,
                         input int d, input bit w, input bit l, input bit h, input bit f);
        id_valid = v; src[0] = AW'(s0); src[1] = AW'(s1); src[2] = AW'(s2); used = u;
        rd = AW'(d); reg_write = w; is_load = l; hold = h; flush = f;
    endtask

    // Called 1 time unit after a rising edge; checks mid-cycle, then crosses the next edge
    task automatic settle();
        #3;
        for (int m = 0; m < 2; m++) begin
            model_eval(m);
            model_compare(m);
        end
    endtask

    task automatic advance();
        for (int m = 0; m < 2; m++) model_step(m);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check_val("rst_sel_a",  32'(sel_a),  0);
        check_val("rst_sel_b",  32'(sel_b),  0);
        check_val("rst_stall",  32'({stall_a, stall_b}), 0);
        check_val("rst_cnt_a",  32'({scnt_a, fcnt_a}), 0);
        check_val("rst_cnt_b",  32'({scnt_b, fcnt_b}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        model_clear();
        #12;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Producer x5 then a consumer one cycle later
        drive(1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0); settle(); advance();
        drive(1, 5, 0, 0, 3'b001, 0, 0, 0, 0, 0); settle();
        check_val("tp_fwd_exe", 32'(sel_a[1:0]), 1);
        advance();
        // Load x7 followed by a dependent: one stall, then forward from MEM
        drive(1, 0, 0, 0, 3'b000, 7, 1, 1, 0, 0); settle(); advance();
        drive(1, 0, 7, 0, 3'b010, 0, 0, 0, 0, 0); settle();
        check_val("tp_ld_stall", 32'(stall_a), 1);
        advance();
        settle();
        check_val("tp_ld_fwd_mem", 32'({stall_a, sel_a[3:2]}), 2);
        advance();
        // Two writers of x3: youngest wins; then writers of x0 never forward
        drive(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0); settle(); advance();
        drive(1, 3, 3, 3, 3'b111, 0, 1, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 3'b111, 0, 1, 1, 0, 0); settle(); advance();
        // Unused source, then flush during a load-use case
        drive(1, 0, 0, 0, 3'b000, 9, 1, 1, 0, 0); settle(); advance();
        drive(1, 0, 9, 9, 3'b001, 0, 0, 0, 0, 0); settle(); advance();
        drive(1, 0, 0, 0, 3'b000, 9, 1, 1, 0, 0); settle(); advance();
        drive(1, 9, 9, 9, 3'b111, 0, 0, 0, 0, 1); settle(); advance();
        // Hold for three cycles with a load in stage 1
        drive(1, 0, 0, 0, 3'b000, 4, 1, 1, 0, 0); settle(); advance();
        for (int c = 0; c < 3; c++) begin
            drive(1, 4, 4, 4, 3'b111, 0, 0, 0, 1, 0); settle(); advance();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, 4, 4, 4, 3'b111, 0, 0, 0, 0, 0); settle(); advance();
        end

        // Randomized traffic with an asynchronous reset pulse in the middle
        for (int it = 0; it < 1500; it++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 3'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            if (it == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_state();
                model_clear();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the in-order RV pipeline; sits in ID.
- Tracks its own shift-register copy of destination info for the NUM_FWD stages downstream of ID.
- Per stage it tracks rd, reg_write and is_load. Stage 1 is EXE, stage 2 is MEM, stage 3 is WB, and so on.
- Produces a forward select per source operand and a load-use stall. Replaces the fixed 2-source, 2-stage combinational calculator.

Parameters:
- NUM_SRC, 2: number of source operands decoded in ID (1..4).
- NUM_FWD, 2: number of downstream stages tracked and forwardable (1..6).
- REG_AW, 5: register address width; register 0 is hardwired zero.
- LOAD_STAGE, 2: first stage index at which load data can be forwarded (1..NUM_FWD).
- SELW, $clog2(NUM_FWD+1): derived width of one forward select. Not overridable.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global pipeline freeze (memory wait); tracked stages keep their values
- flush  in  1  branch/jump flush; the instruction leaving ID becomes a bubble
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses; source i is in bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  source i is actually read (decoder clears it for imm/jal forms)
- id_rd_addr  in  REG_AW  destination register of the ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- fwd_sel  out  NUM_SRC*SELW  per source: 0 = register file, k = stage k
- stall  out  1  load-use stall: hold PC/IF/ID, insert a bubble into stage 1
- stall_cnt  out  16  saturating stall-cycle counter
- fwd_cnt  out  16  saturating forwarded-operand counter

Behaviour:
- State: per stage k (1..NUM_FWD), registers v[k], rd[k], wr[k], ld[k].
- Reset:
  - All v, wr, ld registers and both counters clear to 0; the async clear is applied immediately.
  - The outputs then read fwd_sel=0 and stall=0.
- Match rule: source i matches stage k when all of the following hold:
  - id_valid, id_src_used[i] and v[k] and wr[k] are 1;
  - src[i] != 0;
  - src[i] == rd[k].
- fwd_sel[i]:
  - Combinational; equals the smallest k that matches (the youngest producer wins). 0 if none match.
  - If the winning stage k has ld[k]=1 and k < LOAD_STAGE, then fwd_sel[i]=0 and that source raises stall.
  - An older matching stage must NOT be selected in that case; the data is stale.
- stall: OR over all sources of the load-not-ready condition above. It is forced to 0 when flush=1.
- Update at the clock edge, in priority order:
  - hold=1: no state change; counters also hold.
  - Otherwise stages shift: stage k+1 takes stage k, and the stage-NUM_FWD entry is discarded.
  - Stage 1 loads {id_valid, id_rd_addr, id_reg_write, id_is_load}.
  - Stage 1 instead loads a bubble (v=0, wr=0, ld=0) if stall=1 or flush=1.
- Latency: an instruction reaches stage k exactly k non-hold cycles after leaving ID.
  - A load with LOAD_STAGE=2 followed directly by a dependent instruction gives exactly 1 stall cycle. The dependent then forwards from stage 2.
- Simultaneous events:
  - hold dominates flush and stall.
  - flush dominates stall.
  - A source with rd=0 never forwards and never stalls.
- Reset asserted mid-operation: all stages become bubbles immediately; no stale forwards after release.
- Counters, when not holding and not in reset:
  - stall_cnt increments by 1 per stall cycle.
  - fwd_cnt increments by the number of sources with fwd_sel != 0 and stall=0.
  - Both saturate at 16'hFFFF.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
  - Defined: stall_cnt and fwd_cnt are live as described above.
  - Undefined: no counter registers are built and both ports are tied to 16'h0. Forwarding and stall behaviour is identical in both builds.

Decomposition:
- Shared package / header rv_pipe_pkg holds:
  - REG_AW default;
  - FWD_SEL_RF = 0 and the stage-index naming STG_EXE=1, STG_MEM=2, STG_WB=3;
  - the stage-entry typedef {v, rd, wr, ld}.
- One natural sub-module: fwd_src_match. It is instantiated NUM_SRC times and handles one source:
  - inputs: one source address, its used bit, and the stage vectors;
  - outputs: that source's sel and load-stall bit;
  - implemented as a priority scan.
- The top keeps the shift register, the stall OR and the counters.

Test Plan:
- Default params; stage 1 has rd=5 wr=1 ld=0; ID src0=5 used -> fwd_sel[0]=1, stall=0; next edge fwd_cnt=1.
- Load x7 enters stage 1, ID src1=7 used -> stall=1, sel=0. Next edge stage 1 is a bubble and stage 2 holds the load -> stall=0, fwd_sel[1]=2, stall_cnt=1.
- Stage 1 and stage 2 both write x3, ID src0=src1=3 -> both sels = 1 (youngest wins). The same case with src=0 -> sels 0, no stall.
- id_src_used[1]=0 with src1 matching stage 1 -> sel 0. flush=1 during a load-use case -> stall=0 and stage 1 gets a bubble.
- hold=1 for 3 cycles with a load in stage 1 -> state frozen, stall stays 1, stall_cnt unchanged. Release -> normal progression.
- NUM_SRC=3, NUM_FWD=3, LOAD_STAGE=3: a load in stage 2 matching src2 -> stall. rst_n pulsed low mid-sequence -> all sels 0 and counters 0 asynchronously.
